// File: rtl/axis_pkg.sv
// Shared types and helpers for the round-robin AXI-Stream packet mux.
package axis_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // Round-robin start position after a packet: one past the winner, wrapping to 0.
  function automatic int rr_next(input int idx, input int num_ports);
    return (idx + 1 >= num_ports) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/axis_rr_arbiter.sv
// Combinational rotating-priority search: first asserted request at or above ptr, modulo NUM_PORTS.
module axis_rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic                 gnt_valid,
  output logic [IDX_W-1:0]     gnt_idx
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Offsets are walked from farthest to nearest so the request closest to ptr wins last.
  always_comb begin
    gnt_valid = |req;
    gnt_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int off = NUM_PORTS - 1; off >= 0; off--) begin
      cand = int'(ptr) + off;
      if (cand >= NUM_PORTS) begin
        cand = cand - NUM_PORTS;
      end
      cand_idx = IDX_W'(cand);
      if (req[cand_idx]) begin
        gnt_idx = cand_idx;
      end
    end
  end

endmodule

// File: rtl/axis_arb_mux.sv
// N:1 AXI-Stream mux with packet-granular round-robin arbitration and a registered master stage.
module axis_arb_mux
  import axis_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1,
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_tdata,
  input  logic [NUM_PORTS*KEEP_WIDTH-1:0]  s_tkeep,
  input  logic [NUM_PORTS*USER_WIDTH-1:0]  s_tuser,
  input  logic [NUM_PORTS*ID_WIDTH-1:0]    s_tid,
  input  logic [NUM_PORTS*DEST_WIDTH-1:0]  s_tdest,
  input  logic [NUM_PORTS-1:0]             s_tvalid,
  input  logic [NUM_PORTS-1:0]             s_tlast,
  output logic [NUM_PORTS-1:0]             s_tready,
  output logic [DATA_WIDTH-1:0]            m_tdata,
  output logic [KEEP_WIDTH-1:0]            m_tkeep,
  output logic [USER_WIDTH-1:0]            m_tuser,
  output logic [ID_WIDTH-1:0]              m_tid,
  output logic [DEST_WIDTH-1:0]            m_tdest,
  output logic                             m_tvalid,
  output logic                             m_tlast,
  input  logic                             m_tready,
  output logic [$clog2(NUM_PORTS)-1:0]     grant_idx,
  output logic                             busy
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic             arb_valid;
  logic [IDX_W-1:0] arb_idx;
  logic             out_ready;
  logic             beat;

  logic                  sel_tvalid, sel_tlast;
  logic [DATA_WIDTH-1:0] sel_tdata;
  logic [KEEP_WIDTH-1:0] sel_tkeep;
  logic [USER_WIDTH-1:0] sel_tuser;
  logic [ID_WIDTH-1:0]   sel_tid;
  logic [DEST_WIDTH-1:0] sel_tdest;

  logic                  m_tvalid_q, m_tvalid_d;
  logic                  m_tlast_q, m_tlast_d;
  logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic [KEEP_WIDTH-1:0] m_tkeep_q, m_tkeep_d;
  logic [USER_WIDTH-1:0] m_tuser_q, m_tuser_d;
  logic [ID_WIDTH-1:0]   m_tid_q, m_tid_d;
  logic [DEST_WIDTH-1:0] m_tdest_q, m_tdest_d;

  axis_rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_rr_arbiter (
    .req       (s_tvalid),
    .ptr       (rr_ptr_q),
    .gnt_valid (arb_valid),
    .gnt_idx   (arb_idx)
  );

  assign sel_tvalid = s_tvalid[grant_q];
  assign sel_tlast  = s_tlast[grant_q];
  assign sel_tdata  = s_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
  assign sel_tkeep  = s_tkeep[grant_q*KEEP_WIDTH +: KEEP_WIDTH];
  assign sel_tuser  = s_tuser[grant_q*USER_WIDTH +: USER_WIDTH];
  assign sel_tid    = s_tid[grant_q*ID_WIDTH +: ID_WIDTH];
  assign sel_tdest  = s_tdest[grant_q*DEST_WIDTH +: DEST_WIDTH];

  // The output register can take a beat when empty or draining this cycle.
  assign out_ready = !m_tvalid_q || m_tready;
  assign beat      = (state_q == ARB_BUSY) && sel_tvalid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    case (state_q)
      ARB_IDLE: begin
        if (arb_valid) begin
          grant_d = arb_idx;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (beat && sel_tlast) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = IDX_W'(rr_next(int'(grant_q), NUM_PORTS));
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    s_tready = '0;
    busy     = 1'b0;
    if (state_q == ARB_BUSY) begin
      busy              = 1'b1;
      s_tready[grant_q] = out_ready;
    end
  end

  always_comb begin
    m_tvalid_d = m_tvalid_q;
    m_tlast_d  = m_tlast_q;
    m_tdata_d  = m_tdata_q;
    m_tkeep_d  = m_tkeep_q;
    m_tuser_d  = m_tuser_q;
    m_tid_d    = m_tid_q;
    m_tdest_d  = m_tdest_q;
    if (beat) begin
      m_tvalid_d = 1'b1;
      m_tlast_d  = sel_tlast;
      m_tdata_d  = sel_tdata;
      m_tkeep_d  = sel_tkeep;
      m_tuser_d  = sel_tuser;
      m_tid_d    = sel_tid;
      m_tdest_d  = sel_tdest;
    end else if (m_tvalid_q && m_tready) begin
      m_tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      m_tdata_q  <= '0;
      m_tkeep_q  <= '0;
      m_tuser_q  <= '0;
      m_tid_q    <= '0;
      m_tdest_q  <= '0;
    end else begin
      m_tvalid_q <= m_tvalid_d;
      m_tlast_q  <= m_tlast_d;
      m_tdata_q  <= m_tdata_d;
      m_tkeep_q  <= m_tkeep_d;
      m_tuser_q  <= m_tuser_d;
      m_tid_q    <= m_tid_d;
      m_tdest_q  <= m_tdest_d;
    end
  end

  assign m_tvalid  = m_tvalid_q;
  assign m_tlast   = m_tlast_q;
  assign m_tdata   = m_tdata_q;
  assign m_tkeep   = m_tkeep_q;
  assign m_tuser   = m_tuser_q;
  assign m_tid     = m_tid_q;
  assign m_tdest   = m_tdest_q;
  assign grant_idx = grant_q;

endmodule

// File: tb/tb_axis_arb_mux.sv
// Directed bench for axis_arb_mux: reset, single packet, wrap, contention, backpressure,
// mid-packet reset and single-beat alternation, each against hand-derived beat/cycle tables.
module tb_axis_arb_mux;
  localparam int NP = 4;
  localparam int DW = 32;
  localparam int KW = 4;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP*DW-1:0] s_tdata;
  logic [NP*KW-1:0] s_tkeep;
  logic [NP-1:0]    s_tuser, s_tid, s_tdest, s_tvalid, s_tlast, s_tready;
  logic [DW-1:0]    m_tdata;
  logic [KW-1:0]    m_tkeep;
  logic             m_tuser, m_tid, m_tdest, m_tvalid, m_tlast, m_tready;
  logic [IW-1:0]    grant_idx;
  logic             busy;

  always #5 clk = ~clk;

  axis_arb_mux #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tuser(s_tuser), .s_tid(s_tid), .s_tdest(s_tdest),
    .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tuser(m_tuser), .m_tid(m_tid), .m_tdest(m_tdest),
    .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .grant_idx(grant_idx), .busy(busy)
  );

  // Per-port source beat lists, master-side beat log and per-cycle output history.
  logic [DW-1:0] src_data [NP][32];
  logic          src_last [NP][32];
  int            src_len  [NP];
  int            src_pos  [NP];

  logic [DW-1:0] out_data [64];
  logic          out_last [64];
  logic [KW-1:0] out_keep [64];
  logic [2:0]    out_side [64];
  int            out_cyc  [64];
  int            out_cnt;

  logic [DW-1:0] hd [512];
  logic          hv [512];
  logic          hl [512];
  logic          hb [512];
  logic [IW-1:0] hg [512];

  int cyc;
  int checks = 0;
  int passed = 0;

  function automatic logic [8:0] hx(input int c);
    return c[8:0];
  endfunction

  function automatic logic [KW-1:0] keep_of(input logic [DW-1:0] d);
    return d[3:0] ^ 4'h5;
  endfunction

  function automatic logic [2:0] side_of(input logic [DW-1:0] d);
    return d[6:4];
  endfunction

  function automatic bit pending();
    bit r;
    r = 1'b0;
    for (int p = 0; p < NP; p++) if (src_pos[p] < src_len[p]) r = 1'b1;
    return r;
  endfunction

  task automatic clear_srcs();
    for (int p = 0; p < NP; p++) begin
      src_len[p] = 0;
      src_pos[p] = 0;
    end
  endtask

  task automatic clear_out();
    out_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      out_data[i] = '0;
      out_last[i] = 1'b0;
      out_cyc[i]  = -1;
    end
  endtask

  task automatic load(input int p, input int n, input logic [DW-1:0] base);
    for (int k = 0; k < n; k++) begin
      src_data[p][src_len[p]] = base + DW'(k);
      src_last[p][src_len[p]] = (k == n - 1);
      src_len[p]++;
    end
  endtask

  task automatic drive_srcs();
    for (int p = 0; p < NP; p++) begin
      if (src_pos[p] < src_len[p]) begin
        s_tvalid[p]         = 1'b1;
        s_tdata[p*DW +: DW] = src_data[p][src_pos[p]];
        s_tlast[p]          = src_last[p][src_pos[p]];
      end else begin
        s_tvalid[p]         = 1'b0;
        s_tdata[p*DW +: DW] = 32'hDEAD_0000 | DW'(p);
        s_tlast[p]          = 1'b1;
      end
      s_tkeep[p*KW +: KW] = keep_of(s_tdata[p*DW +: DW]);
      s_tuser[p]          = s_tdata[p*DW + 4];
      s_tid[p]            = s_tdata[p*DW + 5];
      s_tdest[p]          = s_tdata[p*DW + 6];
    end
  endtask

  // One clock: sample just after the negedge drive point, step, then present next beats.
  task automatic tick();
    logic [NP-1:0] hs;
    #1;
    hs = s_tvalid & s_tready;
    hd[hx(cyc)] = m_tdata;
    hv[hx(cyc)] = m_tvalid;
    hl[hx(cyc)] = m_tlast;
    hb[hx(cyc)] = busy;
    hg[hx(cyc)] = grant_idx;
    if (m_tvalid && m_tready && out_cnt < 64) begin
      out_data[out_cnt] = m_tdata;
      out_last[out_cnt] = m_tlast;
      out_keep[out_cnt] = m_tkeep;
      out_side[out_cnt] = {m_tdest, m_tid, m_tuser};
      out_cyc[out_cnt]  = cyc;
      $display("beat cyc=%0d data=%h last=%b keep=%h grant=%0d", cyc, m_tdata, m_tlast, m_tkeep, grant_idx);
      out_cnt++;
    end
    @(posedge clk);
    @(negedge clk);
    for (int p = 0; p < NP; p++) if (hs[p]) src_pos[p]++;
    cyc++;
    drive_srcs();
  endtask

  task automatic run_drain(input int max_cyc, input string name);
    int n;
    n = 0;
    while ((pending() || m_tvalid || busy) && n < max_cyc) begin
      tick();
      n++;
    end
    checks++;
    if (n >= max_cyc) $display("FAIL %s_timeout: still active after %0d cycles, required idle", name, n);
    else passed++;
  endtask

  task automatic apply_reset();
    clear_srcs();
    drive_srcs();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    drive_srcs();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    m_tready = 1'b1;
    clear_srcs();
    load(0, 1, 32'h0000_0001);
    drive_srcs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checks++; if (m_tvalid !== 1'b0) $display("FAIL reset_m_tvalid: got %b expected 0", m_tvalid); else passed++;
    checks++; if (m_tlast !== 1'b0) $display("FAIL reset_m_tlast: got %b expected 0", m_tlast); else passed++;
    checks++; if (m_tdata !== '0) $display("FAIL reset_m_tdata: got %h expected 0", m_tdata); else passed++;
    checks++; if ({m_tkeep, m_tdest, m_tid, m_tuser} !== '0) $display("FAIL reset_m_side: got %h expected 0", {m_tkeep, m_tdest, m_tid, m_tuser}); else passed++;
    checks++; if (s_tready !== '0) $display("FAIL reset_s_tready: got %b expected 0000", s_tready); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    checks++; if (grant_idx !== '0) $display("FAIL reset_grant: got %0d expected 0", grant_idx); else passed++;
    clear_srcs();
    drive_srcs();
    rst = 1'b1;
    @(negedge clk);
    drive_srcs();
  endtask

  task automatic test_single();
    int s;
    clear_out();
    s = cyc;
    load(2, 3, 32'h0200_0010);
    drive_srcs();
    run_drain(30, "single");
    checks++; if (hv[hx(s)] !== 1'b0 || hv[hx(s+1)] !== 1'b0 || hv[hx(s+2)] !== 1'b1)
      $display("FAIL single_latency: got m_tvalid %b%b%b expected 001", hv[hx(s)], hv[hx(s+1)], hv[hx(s+2)]); else passed++;
    checks++; if (hb[hx(s)] !== 1'b0 || hb[hx(s+1)] !== 1'b1)
      $display("FAIL single_busy: got %b%b expected 01", hb[hx(s)], hb[hx(s+1)]); else passed++;
    checks++; if (hg[hx(s+1)] !== 2'd2) $display("FAIL single_grant: got %0d expected 2", hg[hx(s+1)]); else passed++;
    checks++; if (out_cnt !== 3) $display("FAIL single_count: got %0d expected 3", out_cnt); else passed++;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_data[i] !== 32'h0200_0010 + DW'(i) || out_last[i] !== (i == 2) || out_cyc[i] !== s + 2 + i ||
          out_keep[i] !== keep_of(32'h0200_0010 + DW'(i)) || out_side[i] !== 3'b001)
        $display("FAIL single_beat%0d: got data=%h last=%b cyc=%0d keep=%h side=%b expected data=%h last=%b cyc=%0d keep=%h side=001",
                 i, out_data[i], out_last[i], out_cyc[i] - s, out_keep[i], out_side[i],
                 32'h0200_0010 + DW'(i), (i == 2), 2 + i, keep_of(32'h0200_0010 + DW'(i)));
      else passed++;
    end
  endtask

  task automatic test_wrap();
    int s;
    logic [DW-1:0] exp_d [4];
    int exp_off [4];
    exp_d   = '{32'h0300_0050, 32'h0300_0051, 32'h0000_0050, 32'h0000_0051};
    exp_off = '{2, 3, 5, 6};
    clear_out();
    s = cyc;
    load(0, 2, 32'h0000_0050);
    load(3, 2, 32'h0300_0050);
    drive_srcs();
    run_drain(30, "wrap");
    checks++; if (hg[hx(s+1)] !== 2'd3) $display("FAIL wrap_grant: got %0d expected 3", hg[hx(s+1)]); else passed++;
    checks++; if (out_cnt !== 4) $display("FAIL wrap_count: got %0d expected 4", out_cnt); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_data[i] !== exp_d[i] || out_last[i] !== (i % 2 == 1) || out_cyc[i] !== s + exp_off[i])
        $display("FAIL wrap_beat%0d: got data=%h last=%b cyc=%0d expected data=%h last=%b cyc=%0d",
                 i, out_data[i], out_last[i], out_cyc[i] - s, exp_d[i], (i % 2 == 1), exp_off[i]);
      else passed++;
    end
  endtask

  task automatic test_contention();
    int s;
    logic [DW-1:0] exp_d [6];
    int exp_off [6];
    exp_d   = '{32'h0000_0030, 32'h0000_0031, 32'h0100_0030, 32'h0100_0031, 32'h0300_0030, 32'h0300_0031};
    exp_off = '{2, 3, 5, 6, 8, 9};
    apply_reset();
    clear_out();
    s = cyc;
    load(0, 2, 32'h0000_0030);
    load(1, 2, 32'h0100_0030);
    load(3, 2, 32'h0300_0030);
    drive_srcs();
    run_drain(40, "contention");
    checks++; if (out_cnt !== 6) $display("FAIL contention_count: got %0d expected 6", out_cnt); else passed++;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (out_data[i] !== exp_d[i] || out_last[i] !== (i % 2 == 1) || out_cyc[i] !== s + exp_off[i])
        $display("FAIL contention_beat%0d: got data=%h last=%b cyc=%0d expected data=%h last=%b cyc=%0d",
                 i, out_data[i], out_last[i], out_cyc[i] - s, exp_d[i], (i % 2 == 1), exp_off[i]);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    int s;
    int n;
    int idx;
    clear_out();
    s = cyc;
    load(1, 4, 32'h0100_0070);
    drive_srcs();
    n = 0;
    while ((pending() || m_tvalid || busy) && n < 30) begin
      m_tready = ((cyc - s) % 2 == 0);
      tick();
      n++;
    end
    m_tready = 1'b1;
    checks++; if (n >= 30) $display("FAIL bp_timeout: still active after %0d cycles, required idle", n); else passed++;
    checks++; if (out_cnt !== 4) $display("FAIL bp_count: got %0d expected 4", out_cnt); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_data[i] !== 32'h0100_0070 + DW'(i) || out_last[i] !== (i == 3) || out_cyc[i] !== s + 2 + 2 * i)
        $display("FAIL bp_beat%0d: got data=%h last=%b cyc=%0d expected data=%h last=%b cyc=%0d",
                 i, out_data[i], out_last[i], out_cyc[i] - s, 32'h0100_0070 + DW'(i), (i == 3), 2 + 2 * i);
      else passed++;
    end
    for (int k = 2; k <= 8; k++) begin
      idx = (k - 1) / 2;
      checks++;
      if (hv[hx(s+k)] !== 1'b1 || hd[hx(s+k)] !== 32'h0100_0070 + DW'(idx) || hl[hx(s+k)] !== (idx == 3))
        $display("FAIL bp_hold_cyc%0d: got valid=%b data=%h last=%b expected valid=1 data=%h last=%b",
                 k, hv[hx(s+k)], hd[hx(s+k)], hl[hx(s+k)], 32'h0100_0070 + DW'(idx), (idx == 3));
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    int s;
    logic [DW-1:0] exp_d [4];
    int exp_off [4];
    exp_d   = '{32'h0100_00A0, 32'h0100_00A1, 32'h0300_00A0, 32'h0300_00A1};
    exp_off = '{2, 3, 5, 6};
    clear_out();
    load(0, 4, 32'h0000_0090);
    drive_srcs();
    repeat (3) tick();
    #1;
    checks++; if (m_tvalid !== 1'b1 || m_tdata !== 32'h0000_0091)
      $display("FAIL rstmid_pre: got valid=%b data=%h expected valid=1 data=00000091", m_tvalid, m_tdata); else passed++;
    rst = 1'b0;
    #1;
    checks++; if (m_tvalid !== 1'b0 || m_tlast !== 1'b0) $display("FAIL rstmid_valid: got valid=%b last=%b expected 0 0", m_tvalid, m_tlast); else passed++;
    checks++; if (m_tdata !== '0) $display("FAIL rstmid_data: got %h expected 0", m_tdata); else passed++;
    checks++; if (s_tready !== '0 || busy !== 1'b0 || grant_idx !== '0)
      $display("FAIL rstmid_ctrl: got ready=%b busy=%b grant=%0d expected 0000 0 0", s_tready, busy, grant_idx); else passed++;
    src_len[0] = src_pos[0];
    drive_srcs();
    @(negedge clk);
    rst = 1'b1;
    clear_out();
    s = cyc;
    load(1, 2, 32'h0100_00A0);
    load(3, 2, 32'h0300_00A0);
    drive_srcs();
    run_drain(40, "rstmid");
    checks++; if (hg[hx(s+1)] !== 2'd1) $display("FAIL rstmid_grant: got %0d expected 1", hg[hx(s+1)]); else passed++;
    checks++; if (out_cnt !== 4) $display("FAIL rstmid_count: got %0d expected 4", out_cnt); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_data[i] !== exp_d[i] || out_last[i] !== (i % 2 == 1) || out_cyc[i] !== s + exp_off[i])
        $display("FAIL rstmid_beat%0d: got data=%h last=%b cyc=%0d expected data=%h last=%b cyc=%0d",
                 i, out_data[i], out_last[i], out_cyc[i] - s, exp_d[i], (i % 2 == 1), exp_off[i]);
      else passed++;
    end
  endtask

  task automatic test_single_beat();
    int s;
    logic [DW-1:0] exp_d [6];
    logic [IW-1:0] exp_g [4];
    exp_d = '{32'h0000_00B0, 32'h0100_00B0, 32'h0000_00B1, 32'h0100_00B1, 32'h0000_00B2, 32'h0100_00B2};
    exp_g = '{2'd0, 2'd1, 2'd0, 2'd1};
    clear_out();
    s = cyc;
    for (int k = 0; k < 3; k++) begin
      load(0, 1, 32'h0000_00B0 + DW'(k));
      load(1, 1, 32'h0100_00B0 + DW'(k));
    end
    drive_srcs();
    run_drain(40, "single_beat");
    checks++; if (out_cnt !== 6) $display("FAIL sbeat_count: got %0d expected 6", out_cnt); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (hg[hx(s + 1 + 2 * i)] !== exp_g[i])
        $display("FAIL sbeat_grant%0d: got %0d expected %0d", i, hg[hx(s + 1 + 2 * i)], exp_g[i]);
      else passed++;
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (out_data[i] !== exp_d[i] || out_last[i] !== 1'b1 || out_cyc[i] !== s + 2 + 2 * i)
        $display("FAIL sbeat_beat%0d: got data=%h last=%b cyc=%0d expected data=%h last=1 cyc=%0d",
                 i, out_data[i], out_last[i], out_cyc[i] - s, exp_d[i], 2 + 2 * i);
      else passed++;
    end
  endtask

  initial begin
    rst      = 1'b0;
    m_tready = 1'b1;
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tuser  = '0;
    s_tid    = '0;
    s_tdest  = '0;
    cyc      = 0;
    clear_srcs();
    clear_out();
    test_reset();
    test_single();
    test_wrap();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_single_beat();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
